// File: rtl/encoder_8b10b_sync_if.sv
// Byte-in / symbol-out bundle for the 8b/10b encoder.
// master = upstream TX logic, slave = encoder.
interface encoder_8b10b_sync_if;
    logic       DF;   // running disparity at symbol start
    logic       K;    // control character select
    logic [7:0] DI;   // HGFEDCBA
    logic       DE;   // running disparity after DO
    logic [9:0] DO;   // abcdei_fghj, DO[9]=a

    modport master (output DF, output K, output DI, input DE, input DO);
    modport slave  (input DF, input K, input DI, output DE, output DO);
endinterface

// File: rtl/encoder_8b10b_sync.sv
// Registered 8b/10b encoder: one byte plus entry disparity in, one 10-bit
// symbol plus exit disparity out, one cycle later. Disparity is chained by
// the caller (DE fed back to DF).
module encoder_8b10b_sync (
    input  logic                 CLK,
    input  logic                 RST,
    encoder_8b10b_sync_if.slave  bus
);
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_kx7;
    logic       w_a7;
    logic [5:0] w_6b_n;
    logic       w_6b_unbal;
    logic [5:0] w_6b;
    logic       w_rd_mid;
    logic [3:0] w_4b_n;
    logic       w_4b_unbal;
    logic       w_4b_inv;
    logic [3:0] w_4b;
    logic [9:0] r_do;
    logic       r_de;

    assign w_x   = bus.DI[4:0];
    assign w_y   = bus.DI[7:5];
    assign w_k28 = bus.K && (w_x == 5'd28);
    // K23/27/28/29/30.7 are the only K.x.7 codes; other K bytes fall back to data.
    assign w_kx7 = bus.K && (w_y == 3'd7) &&
                   ((w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd28) ||
                    (w_x == 5'd29) || (w_x == 5'd30));

    // 5b/6b lookup: RD- form plus whether the code is unbalanced
    always_comb begin
        {w_6b_unbal, w_6b_n} = 7'b0_000000;
        if (w_k28) begin
            {w_6b_unbal, w_6b_n} = 7'b1_001111;
        end else begin
            case (w_x)
                5'd0:  {w_6b_unbal, w_6b_n} = 7'b1_100111;
                5'd1:  {w_6b_unbal, w_6b_n} = 7'b1_011101;
                5'd2:  {w_6b_unbal, w_6b_n} = 7'b1_101101;
                5'd3:  {w_6b_unbal, w_6b_n} = 7'b0_110001;
                5'd4:  {w_6b_unbal, w_6b_n} = 7'b1_110101;
                5'd5:  {w_6b_unbal, w_6b_n} = 7'b0_101001;
                5'd6:  {w_6b_unbal, w_6b_n} = 7'b0_011001;
                5'd7:  {w_6b_unbal, w_6b_n} = 7'b0_111000;
                5'd8:  {w_6b_unbal, w_6b_n} = 7'b1_111001;
                5'd9:  {w_6b_unbal, w_6b_n} = 7'b0_100101;
                5'd10: {w_6b_unbal, w_6b_n} = 7'b0_010101;
                5'd11: {w_6b_unbal, w_6b_n} = 7'b0_110100;
                5'd12: {w_6b_unbal, w_6b_n} = 7'b0_001101;
                5'd13: {w_6b_unbal, w_6b_n} = 7'b0_101100;
                5'd14: {w_6b_unbal, w_6b_n} = 7'b0_011100;
                5'd15: {w_6b_unbal, w_6b_n} = 7'b1_010111;
                5'd16: {w_6b_unbal, w_6b_n} = 7'b1_011011;
                5'd17: {w_6b_unbal, w_6b_n} = 7'b0_100011;
                5'd18: {w_6b_unbal, w_6b_n} = 7'b0_010011;
                5'd19: {w_6b_unbal, w_6b_n} = 7'b0_110010;
                5'd20: {w_6b_unbal, w_6b_n} = 7'b0_001011;
                5'd21: {w_6b_unbal, w_6b_n} = 7'b0_101010;
                5'd22: {w_6b_unbal, w_6b_n} = 7'b0_011010;
                5'd23: {w_6b_unbal, w_6b_n} = 7'b1_111010;
                5'd24: {w_6b_unbal, w_6b_n} = 7'b1_110011;
                5'd25: {w_6b_unbal, w_6b_n} = 7'b0_100110;
                5'd26: {w_6b_unbal, w_6b_n} = 7'b0_010110;
                5'd27: {w_6b_unbal, w_6b_n} = 7'b1_110110;
                5'd28: {w_6b_unbal, w_6b_n} = 7'b0_001110;
                5'd29: {w_6b_unbal, w_6b_n} = 7'b1_101110;
                5'd30: {w_6b_unbal, w_6b_n} = 7'b1_011110;
                default: {w_6b_unbal, w_6b_n} = 7'b1_101011;
            endcase
        end
    end

    // RD+ form is the complement for unbalanced codes and for the D.07 alternate pair.
    assign w_6b     = (bus.DF && (w_6b_unbal || (w_x == 5'd7))) ? ~w_6b_n : w_6b_n;
    assign w_rd_mid = bus.DF ^ w_6b_unbal;

    // A7 avoids a run of five across the 6b/4b boundary.
    assign w_a7 = w_kx7 ||
                  (!w_rd_mid && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                  ( w_rd_mid && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));

    // 3b/4b lookup: RD- form plus whether the code is unbalanced
    always_comb begin
        {w_4b_unbal, w_4b_n} = 5'b0_0000;
        case (w_y)
            3'd0:    {w_4b_unbal, w_4b_n} = 5'b1_1011;
            3'd1:    {w_4b_unbal, w_4b_n} = 5'b0_1001;
            3'd2:    {w_4b_unbal, w_4b_n} = 5'b0_0101;
            3'd3:    {w_4b_unbal, w_4b_n} = 5'b0_1100;
            3'd4:    {w_4b_unbal, w_4b_n} = 5'b1_1101;
            3'd5:    {w_4b_unbal, w_4b_n} = 5'b0_1010;
            3'd6:    {w_4b_unbal, w_4b_n} = 5'b0_0110;
            default: {w_4b_unbal, w_4b_n} = w_a7 ? 5'b1_0111 : 5'b1_1110;
        endcase
    end

    // K28.1/2/5/6 flip the balanced fghj when entering at intermediate RD-,
    // which is what gives those symbols their comma/K polarity.
    assign w_4b_inv = (w_rd_mid && (w_4b_unbal || (w_y == 3'd3))) ^
                      (w_k28 && !w_rd_mid &&
                       ((w_y == 3'd1) || (w_y == 3'd2) || (w_y == 3'd5) || (w_y == 3'd6)));
    assign w_4b     = w_4b_inv ? ~w_4b_n : w_4b_n;

    // Output register; reset clears the symbol and disparity
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_do <= 10'b0;
            r_de <= 1'b0;
        end else begin
            r_do <= {w_6b, w_4b};
            r_de <= w_rd_mid ^ w_4b_unbal;
        end
    end

    assign bus.DO = r_do;
    assign bus.DE = r_de;
endmodule

// File: tb/tb_encoder_8b10b_sync.sv
// Bench for encoder_8b10b_sync: two-column golden 8b/10b table model,
// per-cycle compare, independent symbol property checks, literal pins.
module tb_encoder_8b10b_sync;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    encoder_8b10b_sync_if bus ();
    encoder_8b10b_sync dut (.CLK(clk), .RST(rst), .bus(bus));

    // Published table, RD- and RD+ columns, index x
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    // Data fghj (y=7 column is P7) and K28 fghj, indexed by y
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KL [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                       8'hF7, 8'hFB, 8'hFD, 8'hFE};

    int total = 0;
    int bad   = 0;

    // Golden encode: returns {DE, DO}
    function automatic logic [10:0] model(input logic k, input logic [7:0] di, input logic df);
        int x, y;
        logic rd, a7;
        logic [5:0] c6;
        logic [3:0] c4;
        x  = int'(di[4:0]);
        y  = int'(di[7:5]);
        if (k && x == 28) c6 = df ? 6'b110000 : 6'b001111;
        else              c6 = df ? T6P[x] : T6N[x];
        rd = ($countones(c6) == 3) ? df : ($countones(c6) > 3);
        if (k && x == 28 && y != 7) begin
            c4 = rd ? K4P[y] : K4N[y];
        end else if (y == 7) begin
            a7 = (k && x inside {23, 27, 28, 29, 30}) ||
                 (!rd && x inside {17, 18, 20}) || (rd && x inside {11, 13, 14});
            if (a7) c4 = rd ? 4'b1000 : 4'b0111;
            else    c4 = rd ? T4P[7] : T4N[7];
        end else begin
            c4 = rd ? T4P[y] : T4N[y];
        end
        if ($countones(c4) != 2) rd = ($countones(c4) > 2);
        return {rd, c6, c4};
    endfunction

    function automatic int maxrun(input logic [9:0] s);
        int m, r;
        m = 1; r = 1;
        for (int i = 1; i < 10; i++) begin
            r = (s[i] == s[i-1]) ? r + 1 : 1;
            if (r > m) m = r;
        end
        return m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs as sampled by the DUT at the most recent rising edge
    logic       s_v = 1'b0;
    logic       s_rst, s_k, s_df;
    logic [7:0] s_di;
    always @(posedge clk) begin
        s_v   <= 1'b1;
        s_rst <= rst;
        s_k   <= bus.K;
        s_df  <= bus.DF;
        s_di  <= bus.DI;
    end

    // Per-cycle compare against the model plus table-free symbol properties
    logic [10:0] e;
    int          disp;
    logic        de_prop;
    always @(negedge clk) begin
        if (s_v) begin
            e = s_rst ? 11'b0 : model(s_k, s_di, s_df);
            check("do", 32'(bus.DO), 32'(e[9:0]));
            check("de", 32'(bus.DE), 32'(e[10]));
            if (!s_rst) begin
                disp    = 2 * $countones(bus.DO) - 10;
                de_prop = (disp > 0) ? 1'b1 : (disp < 0) ? 1'b0 : s_df;
                check("runlen_le5", 32'(maxrun(bus.DO) <= 5), 32'd1);
                check("disp_ok", 32'((disp == 0) || (disp == 2 && !s_df) || (disp == -2 && s_df)), 32'd1);
                check("de_vs_disp", 32'(bus.DE), 32'(de_prop));
            end
        end
    end

    task automatic step(input logic r, input logic k, input logic [7:0] di, input logic df);
        rst    = r;
        bus.K  = k;
        bus.DI = di;
        bus.DF = df;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic k, input logic [7:0] di, input logic df,
                       input logic [9:0] xdo, input logic xde);
        check({nm, "_model"}, 32'(model(k, di, df)), 32'({xde, xdo}));
        step(1'b0, k, di, df);
        @(negedge clk);
        check({nm, "_do"}, 32'(bus.DO), 32'(xdo));
        check({nm, "_de"}, 32'(bus.DE), 32'(xde));
    endtask

    initial begin
        logic k;
        logic [7:0] di;
        repeat (3) step(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
        @(negedge clk);
        check("reset_do", 32'(bus.DO), 32'd0);
        check("reset_de", 32'(bus.DE), 32'd0);

        lit("D00.0_rdn", 1'b0, 8'h00, 1'b0, 10'b1001110100, 1'b0);
        lit("D00.0_rdp", 1'b0, 8'h00, 1'b1, 10'b0110001011, 1'b1);
        lit("K28.5_rdn", 1'b1, 8'hBC, 1'b0, 10'b0011111010, 1'b1);
        lit("K28.5_rdp", 1'b1, 8'hBC, 1'b1, 10'b1100000101, 1'b0);
        lit("D07.0_rdn", 1'b0, 8'h07, 1'b0, 10'b1110001011, 1'b1);
        lit("D17.7_rdn", 1'b0, 8'hF1, 1'b0, 10'b1000110111, 1'b1);
        lit("D01.7_rdn", 1'b0, 8'hE1, 1'b0, 10'b0111010001, 1'b0);
        lit("K28.7_rdn", 1'b1, 8'hFC, 1'b0, 10'b0011111000, 1'b0);
        lit("K23.7_rdp", 1'b1, 8'hF7, 1'b1, 10'b0001010111, 1'b1);

        // Mid-stream reset discards the symbol sampled with it
        step(1'b1, 1'b1, 8'hBC, 1'b1);
        @(negedge clk);
        check("midreset_do", 32'(bus.DO), 32'd0);
        check("midreset_de", 32'(bus.DE), 32'd0);

        // All data bytes at both disparities
        for (int d = 0; d < 2; d++)
            for (int b = 0; b < 256; b++)
                step(1'b0, 1'b0, 8'(b), 1'(d));

        // All valid K characters at both disparities
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 12; i++)
                step(1'b0, 1'b1, KL[i], 1'(d));

        // Random chained stream, DF taken from the previous symbol's DE
        for (int n = 0; n < 2000; n++) begin
            k = ($urandom_range(0, 3) == 0);
            if (k && $urandom_range(0, 1) == 1) di = KL[$urandom_range(0, 11)];
            else                                di = 8'($urandom);
            step(1'b0, k, di, bus.DE);
        end

        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
